ub_vector_reader: RTL

Drains the unified buffer's byte-wide read port, packs consecutive bytes into LANES-wide activation vectors, and launches each vector into the systolic array with a diagonal skew: lane i is delayed i cycles. It sits between the unified buffer read side and the systolic array row inputs. A start/num_vec command drives it, and it reports busy, done and a sticky protocol error.

---
 rtl/tpu_pkg.sv | 14 +
 rtl/lane_skew.sv | 55 +++++
 rtl/ub_vector_reader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: default datapath geometry and the vector reader FSM states.
package tpu_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_LANES = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH,
    DONE
  } rd_state_e;

endpackage

// File: rtl/lane_skew.sv
// Triangular delay line feeding the systolic rows: lane i is held back i cycles
// behind lane 0, and each lane carries its own valid with zeroed data when idle.
module lane_skew #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic [LANES-1:0]       lane_valid,
  output logic [LANES*WIDTH-1:0] lane_data,
  output logic                   pending
);

  // upstream_busy[i]: something is still travelling towards lane i's output
  logic [LANES-1:0] upstream_busy;

  assign lane_valid[0]          = in_valid;
  assign lane_data[0 +: WIDTH]  = in_valid ? in_data[0 +: WIDTH] : '0;
  assign upstream_busy[0]       = 1'b0;

  for (genvar i = 1; i < LANES; i++) begin : g_lane
    logic [i-1:0]     v_q;
    logic [WIDTH-1:0] d_q [i];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q <= '0;
        for (int j = 0; j < i; j++) begin
          d_q[j] <= '0;
        end
      end else begin
        v_q[0] <= in_valid;
        d_q[0] <= in_valid ? in_data[i*WIDTH +: WIDTH] : '0;
        for (int j = 1; j < i; j++) begin
          v_q[j] <= v_q[j-1];
          d_q[j] <= d_q[j-1];
        end
      end
    end

    assign lane_valid[i]              = v_q[i-1];
    assign lane_data[i*WIDTH +: WIDTH] = d_q[i-1];

    if (i > 1) begin : g_inner
      assign upstream_busy[i] = in_valid | (|v_q[i-2:0]);
    end else begin : g_first
      assign upstream_busy[i] = in_valid;
    end
  end

  assign pending = |upstream_busy;

endmodule

// File: rtl/ub_vector_reader.sv
// Pops bytes from the unified buffer, packs LANES of them into a vector and
// launches each vector into the systolic array through a diagonal skew line.
module ub_vector_reader
  import tpu_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int LANES   = DEFAULT_LANES,
  parameter int MAX_VEC = 256,
  parameter int CNT_W   = $clog2(MAX_VEC + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_vec,
  output logic                   busy,
  output logic                   done,
  output logic                   proto_err,
  input  logic                   ub_empty,
  output logic                   ub_rd_ready,
  input  logic                   ub_rd_valid,
  input  logic [WIDTH-1:0]       ub_rd_data,
  output logic [LANES-1:0]       lane_valid,
  output logic [LANES*WIDTH-1:0] lane_data
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int POP_W = CNT_W + $clog2(LANES);

  rd_state_e state_q, state_d;

  logic [POP_W-1:0]       pops_left_q;
  logic [IDX_W-1:0]       byte_idx_q;
  logic                   pop_d_q;
  logic [WIDTH-1:0]       pack_q [LANES];
  logic [LANES*WIDTH-1:0] vec_q;
  logic [LANES*WIDTH-1:0] vec_next;
  logic                   vec_valid_q;

  logic                   accept_start;
  logic [CNT_W-1:0]       num_vec_clamped;
  logic                   pop;
  logic                   last_slot;
  logic                   vec_done;
  logic                   final_capture;
  logic                   skew_pending;

  assign accept_start    = (state_q == IDLE) && start;
  assign num_vec_clamped = (num_vec > CNT_W'(MAX_VEC)) ? CNT_W'(MAX_VEC) : num_vec;
  assign pop             = ub_rd_ready && !ub_empty;
  assign last_slot       = (byte_idx_q == IDX_W'(LANES - 1));
  assign vec_done        = pop_d_q && last_slot;
  // Nothing is left to pop, so this completed vector is the command's last one
  assign final_capture   = vec_done && (pops_left_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (num_vec_clamped == '0) ? DONE : FETCH;
      FETCH:   if (final_capture) state_d = FLUSH;
      FLUSH:   if (!skew_pending) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    ub_rd_ready = (state_q == FETCH) && (pops_left_q != '0);
  end

  // The buffer read is registered, so a pop in one cycle is captured in the next
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pops_left_q <= '0;
      byte_idx_q  <= '0;
      pop_d_q     <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      pop_d_q <= pop;
      if (accept_start) begin
        pops_left_q <= POP_W'(num_vec_clamped) * POP_W'(LANES);
        byte_idx_q  <= '0;
        proto_err   <= 1'b0;
      end else begin
        if (pop) begin
          pops_left_q <= pops_left_q - POP_W'(1);
        end
        if (pop_d_q) begin
          byte_idx_q <= last_slot ? '0 : byte_idx_q + IDX_W'(1);
          if (!ub_rd_valid) begin
            proto_err <= 1'b1;
          end
        end
      end
    end
  end

  // The last byte bypasses the pack register so a vector leaves on its final capture
  always_comb begin
    vec_next = '0;
    for (int k = 0; k < LANES - 1; k++) begin
      vec_next[k*WIDTH +: WIDTH] = pack_q[k];
    end
    vec_next[(LANES-1)*WIDTH +: WIDTH] = ub_rd_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < LANES; k++) begin
        pack_q[k] <= '0;
      end
      vec_q       <= '0;
      vec_valid_q <= 1'b0;
    end else begin
      if (pop_d_q) begin
        pack_q[byte_idx_q] <= ub_rd_data;
      end
      vec_valid_q <= vec_done;
      vec_q       <= vec_done ? vec_next : '0;
    end
  end

  lane_skew #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_lane_skew (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (vec_valid_q),
    .in_data    (vec_q),
    .lane_valid (lane_valid),
    .lane_data  (lane_data),
    .pending    (skew_pending)
  );

endmodule
